// File: rtl/exc_seq_ctrl_if.sv
// Pipeline <-> exception sequencer bundle.
// slave = the sequencer, master = the pipeline side.
interface exc_seq_ctrl_if;
    logic [5:0]  hwint;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        ack_we;
    logic [31:0] ack_addr;
    logic [3:0]  ack_byteen;

    modport slave (
        input  hwint, exc_valid, exc_code, m_pc, m_bd, eret,
        input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        output cp0_rdata, flush, redirect_valid, redirect_pc,
        output epc, ack_we, ack_addr, ack_byteen
    );

    modport master (
        output hwint, exc_valid, exc_code, m_pc, m_bd, eret,
        output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
        input  cp0_rdata, flush, redirect_valid, redirect_pc,
        input  epc, ack_we, ack_addr, ack_byteen
    );
endinterface

// File: rtl/exc_seq_ctrl.sv
// Exception / interrupt entry and eret sequencer with CP0 SR, Cause, EPC.
// Entry: flush x3 (entry, drain, vector), vector to 0x4180, optional int ack.
module exc_seq_ctrl (
    input  logic          clk,
    input  logic          reset,
    exc_seq_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAIN   = 3'd1;
    localparam logic [2:0] VECTOR  = 3'd2;
    localparam logic [2:0] HANDLER = 3'd3;
    localparam logic [2:0] RET     = 3'd4;

    localparam logic [31:0] VEC_PC   = 32'h0000_4180;
    localparam logic [31:0] ACK_ADDR = 32'h0000_7F20;
    localparam logic [4:0]  SR_A     = 5'd12;
    localparam logic [4:0]  CAUSE_A  = 5'd13;
    localparam logic [4:0]  EPC_A    = 5'd14;

    logic [2:0]  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        is_int_q, is_int_d;

    logic        int_pending;
    logic        entry_idle;
    logic        reentry;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        flush;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ack;
    logic        unused_wdata;

    assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

    assign int_pending = (|(bus.hwint & im_q)) & ie_q & ~exl_q;
    assign entry_idle  = reset & (state_q == IDLE)
                       & (int_pending | bus.exc_valid);
    assign reentry     = (state_q == HANDLER) & bus.exc_valid;

    assign sr_val    = {16'h0, im_q, 8'h0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'h0, ip_q, 3'h0, code_q, 2'h0};
    assign ip_d      = bus.hwint;

    // Combinational mfc0 read port
    always_comb begin
        bus.cp0_rdata = 32'h0;
        if (bus.cp0_raddr == SR_A)         bus.cp0_rdata = sr_val;
        else if (bus.cp0_raddr == CAUSE_A) bus.cp0_rdata = cause_val;
        else if (bus.cp0_raddr == EPC_A)   bus.cp0_rdata = epc_q;
    end

    // Sequencer next state, CP0 updates and per-state outputs
    always_comb begin
        state_d  = state_q;
        im_d     = im_q;
        exl_d    = exl_q;
        ie_d     = ie_q;
        bd_d     = bd_q;
        code_d   = code_q;
        epc_d    = epc_q;
        is_int_d = is_int_q;
        flush    = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'h0;
        ack      = 1'b0;

        if (bus.cp0_we && !entry_idle && !reentry) begin
            if (bus.cp0_waddr == SR_A) begin
                im_d  = bus.cp0_wdata[15:10];
                exl_d = bus.cp0_wdata[1];
                ie_d  = bus.cp0_wdata[0];
            end else if (bus.cp0_waddr == EPC_A) begin
                epc_d = {bus.cp0_wdata[31:2], 2'b00};
            end
        end

        unique case (state_q)
            IDLE: begin
                if (entry_idle) begin
                    flush    = 1'b1;
                    state_d  = DRAIN;
                    epc_d    = (bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc)
                             & 32'hFFFF_FFFC;
                    bd_d     = bus.m_bd;
                    exl_d    = 1'b1;
                    code_d   = int_pending ? 5'd0 : bus.exc_code;
                    is_int_d = int_pending;
                end
            end
            DRAIN: begin
                flush   = 1'b1;
                state_d = VECTOR;
            end
            VECTOR: begin
                flush    = 1'b1;
                redir    = 1'b1;
                redir_pc = VEC_PC;
                ack      = is_int_q;
                state_d  = HANDLER;
            end
            HANDLER: begin
                if (bus.exc_valid) begin
                    flush    = 1'b1;
                    code_d   = bus.exc_code;
                    is_int_d = 1'b0;
                    exl_d    = 1'b1;
                    state_d  = DRAIN;
                end else if (bus.eret) begin
                    flush   = 1'b1;
                    state_d = RET;
                end
            end
            RET: begin
                redir    = 1'b1;
                redir_pc = epc_q;
                exl_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.flush          = flush;
    assign bus.redirect_valid = redir;
    assign bus.redirect_pc    = redir_pc;
    assign bus.epc            = epc_q;
    assign bus.ack_we         = ack;
    assign bus.ack_addr       = ack ? ACK_ADDR : 32'h0;
    assign bus.ack_byteen     = ack ? 4'b0001 : 4'b0000;

    // State and CP0 registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            im_q     <= 6'h0;
            exl_q    <= 1'b0;
            ie_q     <= 1'b0;
            bd_q     <= 1'b0;
            ip_q     <= 6'h0;
            code_q   <= 5'h0;
            epc_q    <= 32'h0;
            is_int_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            im_q     <= im_d;
            exl_q    <= exl_d;
            ie_q     <= ie_d;
            bd_q     <= bd_d;
            ip_q     <= ip_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            is_int_q <= is_int_d;
        end
    end
endmodule
